// File: rtl/he_frame_ctrl_if.sv
// Bus bundle between the histogram-equalization frame sequencer and its
// pixel source, histogram RAM and LUT RAM.
interface he_frame_ctrl_if #(
  parameter int CNT_W = 19
);
  // Pixel handshake: a pixel transfers in a cycle where pix_valid and
  // pix_ready are both high; the source holds pix_in stable while
  // pix_valid is high and unaccepted, and ready never depends on valid.
  logic [7:0]       pix_in;
  logic             pix_valid;
  logic             pix_ready;

  logic [7:0]       hist_raddr;
  logic [CNT_W-1:0] hist_rdata;
  logic             hist_we;
  logic [7:0]       hist_waddr;
  logic [CNT_W-1:0] hist_wdata;

  logic             lut_we;
  logic [7:0]       lut_addr;
  logic [7:0]       lut_wdata;

  modport master (
    input  pix_in, pix_valid, hist_rdata,
    output pix_ready, hist_raddr, hist_we, hist_waddr, hist_wdata,
    output lut_we, lut_addr, lut_wdata
  );

  modport slave (
    output pix_in, pix_valid, hist_rdata,
    input  pix_ready, hist_raddr, hist_we, hist_waddr, hist_wdata,
    input  lut_we, lut_addr, lut_wdata
  );
endinterface

// File: rtl/he_frame_ctrl.sv
// Histogram-equalization frame sequencer: clears the histogram, accumulates
// one frame, then walks the CDF to write the 256-entry equalization LUT.
module he_frame_ctrl #(
  parameter int LOG2_PIXELS = 18,
  parameter int CNT_W       = LOG2_PIXELS + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  he_frame_ctrl_if.master bus,
  output logic            busy,
  output logic            done,
  output logic            lut_valid,
  output logic [2:0]      state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_CDF   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'((1 << LOG2_PIXELS) - 1);

  logic [2:0]       state;
  logic [8:0]       step;
  logic [CNT_W-1:0] pix_cnt;
  logic             pend;
  logic [7:0]       pend_addr;
  logic             last_we;
  logic [7:0]       last_addr;
  logic [CNT_W-1:0] last_wdata;
  logic [CNT_W-1:0] sum;

  logic             accept;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] sum_new;
  logic [CNT_W+7:0] prod;

  assign accept  = bus.pix_valid & bus.pix_ready;
  // The RAM returns pre-write data on a same-cycle collision, so a
  // back-to-back hit on one bin must take the value just written.
  assign base    = (last_we && (last_addr == pend_addr)) ? last_wdata : bus.hist_rdata;
  assign sum_new = sum + bus.hist_rdata;
  assign prod    = (CNT_W+8)'(sum_new) * (CNT_W+8)'(255);

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  always_comb begin
    bus.pix_ready  = 1'b0;
    bus.hist_raddr = 8'd0;
    bus.hist_we    = 1'b0;
    bus.hist_waddr = 8'd0;
    bus.hist_wdata = '0;
    bus.lut_we     = 1'b0;
    bus.lut_addr   = 8'd0;
    bus.lut_wdata  = 8'd0;
    case (state)
      S_CLEAR: begin
        bus.hist_we    = 1'b1;
        bus.hist_waddr = step[7:0];
      end
      S_ACCUM, S_DRAIN: begin
        bus.pix_ready  = (state == S_ACCUM);
        bus.hist_raddr = (state == S_ACCUM) ? bus.pix_in : 8'd0;
        if (pend) begin
          bus.hist_we    = 1'b1;
          bus.hist_waddr = pend_addr;
          bus.hist_wdata = base + CNT_W'(1);
        end
      end
      S_CDF: begin
        if (!step[8]) bus.hist_raddr = step[7:0];
        if (step != 9'd0) begin
          bus.lut_we    = 1'b1;
          bus.lut_addr  = 8'(step - 9'd1);
          bus.lut_wdata = 8'(prod >> LOG2_PIXELS);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      step       <= 9'd0;
      pix_cnt    <= '0;
      pend       <= 1'b0;
      pend_addr  <= 8'd0;
      last_we    <= 1'b0;
      last_addr  <= 8'd0;
      last_wdata <= '0;
      sum        <= '0;
      lut_valid  <= 1'b0;
    end else begin
      last_we    <= bus.hist_we;
      last_addr  <= bus.hist_waddr;
      last_wdata <= bus.hist_wdata;
      pend       <= accept;
      if (accept) pend_addr <= bus.pix_in;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CLEAR;
            step      <= 9'd0;
            lut_valid <= 1'b0;
          end
        end
        S_CLEAR: begin
          step <= step + 9'd1;
          if (step == 9'd255) begin
            state   <= S_ACCUM;
            step    <= 9'd0;
            pix_cnt <= '0;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
            if (pix_cnt == PIX_LAST) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state <= S_CDF;
          step  <= 9'd0;
          sum   <= '0;
        end
        S_CDF: begin
          step <= step + 9'd1;
          if (step != 9'd0) sum <= sum_new;
          if (step == 9'd256) state <= S_DONE;
        end
        S_DONE: begin
          lut_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_he_frame_ctrl.sv
// Randomized bench for he_frame_ctrl: histogram RAM model, frame-level
// histogram/CDF reference, LUT write scoreboard and timing checks.
module tb_he_frame_ctrl;
  localparam int LOG2 = 8;
  localparam int CW   = LOG2 + 1;
  localparam int NPIX = 1 << LOG2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       busy, done, lut_valid;
  logic [2:0] state_dbg;

  he_frame_ctrl_if #(.CNT_W(CW)) bus();

  he_frame_ctrl #(.LOG2_PIXELS(LOG2), .CNT_W(CW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .lut_valid (lut_valid),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // histogram RAM: 1-cycle read, old data on same-address collision
  logic [CW-1:0] hist_mem [256];
  always @(posedge clk) begin
    bus.hist_rdata <= hist_mem[bus.hist_raddr];
    if (bus.hist_we) hist_mem[bus.hist_waddr] <= bus.hist_wdata;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // scoreboard state
  logic [15:0] exp_q[$];
  logic [7:0]  lut_mem [256];
  int          clr_idx, acc_cnt, inc_writes, lut_cnt, done_cnt;
  int          rise_cyc, first_acc_cyc, last_acc_cyc, done_cyc;
  bit          prev_acc, prev_ready;
  logic [7:0]  prev_pix;
  bit          exp_lv;

  initial begin
    prev_acc = 0; prev_ready = 0; prev_pix = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_acc = 0;
        prev_ready = 0;
      end else begin
        bit nz_we, acc;
        logic [15:0] e;
        if (bus.pix_ready && !prev_ready) rise_cyc = cyc;
        prev_ready = bus.pix_ready;
        nz_we = bus.hist_we && (bus.hist_wdata != 0);
        if (bus.hist_we && bus.hist_wdata == 0) begin
          check_eq("clear_addr", bus.hist_waddr, clr_idx[7:0]);
          clr_idx++;
        end
        if (prev_acc || nz_we) check_eq("inc_we_delay", nz_we, prev_acc);
        if (prev_acc) check_eq("inc_waddr", bus.hist_waddr, prev_pix);
        if (nz_we) inc_writes++;
        acc = bus.pix_valid && bus.pix_ready;
        if (acc) begin
          if (acc_cnt == 0) first_acc_cyc = cyc;
          acc_cnt++;
          last_acc_cyc = cyc;
        end
        prev_acc = acc;
        prev_pix = bus.pix_in;
        if (bus.lut_we) begin
          lut_cnt++;
          lut_mem[bus.lut_addr] = bus.lut_wdata;
          check_eq("lut_write_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("lut_write", {bus.lut_addr, bus.lut_wdata}, e);
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_pix_ready"}, bus.pix_ready, 0);
    check_eq({tag, "_hist_we"},   bus.hist_we, 0);
    check_eq({tag, "_lut_we"},    bus.lut_we, 0);
    check_eq({tag, "_busy"},      busy, 0);
    check_eq({tag, "_done"},      done, 0);
    check_eq({tag, "_lut_valid"}, lut_valid, 0);
    check_eq({tag, "_addrs"},     {bus.hist_raddr, bus.hist_waddr, bus.lut_addr}, 0);
    check_eq({tag, "_data"},      {bus.hist_wdata, bus.lut_wdata}, 0);
  endtask

  // kind: 0 ramp, 1 constant 0x80, 2 A,A,B,A, 3 narrow random, 4 full random
  task automatic run_frame(input int kind, input int bubble_pct, input bit extra_valid,
                           input bit glitch);
    int px[256];
    int hist_m[256];
    int cdf, i, guard, n, start_cyc;
    int a, b;
    bit v;
    clr_idx = 0; acc_cnt = 0; inc_writes = 0; lut_cnt = 0; done_cnt = 0;
    rise_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
    exp_q.delete();
    check_eq("lut_valid_before_start", lut_valid, exp_lv);

    a = $urandom_range(0, 255);
    b = (a + 1 + $urandom_range(0, 253)) % 256;
    for (int k = 0; k < NPIX; k++) begin
      case (kind)
        0: px[k] = k % 256;
        1: px[k] = 8'h80;
        2: px[k] = (k % 4 == 2) ? b : a;
        3: px[k] = $urandom_range(0, 3);
        default: px[k] = $urandom_range(0, 255);
      endcase
    end
    for (int k = 0; k < 256; k++) hist_m[k] = 0;
    for (int k = 0; k < NPIX; k++) hist_m[px[k]]++;
    cdf = 0;
    for (int k = 0; k < 256; k++) begin
      logic [7:0] ka, ve;
      cdf += hist_m[k];
      ka = k[7:0];
      ve = 8'((cdf * 255) >> LOG2);
      exp_q.push_back({ka, ve});
    end

    i = 0; guard = 0; start_cyc = 0;
    while (i < NPIX && guard < 3000) begin
      @(posedge clk); #1;
      start = (guard == 0) || (glitch && i == 100);
      v = (bubble_pct == 0) || ($urandom_range(0, 99) >= bubble_pct);
      bus.pix_valid = v;
      bus.pix_in = v ? 8'(px[i]) : 8'($urandom_range(0, 255));
      @(negedge clk);
      if (guard == 0) start_cyc = cyc;
      if (guard == 1) begin
        check_eq("lut_valid_cleared", lut_valid, 0);
        check_eq("busy_after_start", busy, 1);
      end
      if (bus.pix_valid && bus.pix_ready) i++;
      guard++;
    end
    check_eq("frame_accepted", i, NPIX);
    exp_lv = 0;

    @(posedge clk); #1;
    start = 0;
    bus.pix_valid = extra_valid;
    bus.pix_in = 8'($urandom_range(0, 255));
    @(negedge clk);
    check_eq("ready_drop", bus.pix_ready, 0);
    repeat (50) @(posedge clk);
    #1 start = glitch;
    @(posedge clk); #1 start = 0;

    n = 0;
    while (done_cnt == 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 bus.pix_valid = 0;
    repeat (6) @(negedge clk);
    exp_lv = 1;

    check_eq("done_count", done_cnt, 1);
    check_eq("done_latency", done_cyc - last_acc_cyc, 259);
    check_eq("ready_rise", rise_cyc - start_cyc, 257);
    check_eq("busy_after_done", busy, 0);
    check_eq("lut_valid_after_done", lut_valid, 1);
    check_eq("clear_writes", clr_idx, 256);
    check_eq("accepts", acc_cnt, NPIX);
    check_eq("inc_writes", inc_writes, NPIX);
    check_eq("lut_writes", lut_cnt, 256);
    check_eq("lut_queue_empty", exp_q.size(), 0);
    if (bubble_pct == 0) check_eq("accum_length", last_acc_cyc - first_acc_cyc, NPIX - 1);
    for (int k = 0; k < 256; k++) check_eq("hist_bin", hist_mem[k], hist_m[k]);
    if (kind == 0) begin
      check_eq("ramp_lut0", lut_mem[0], 0);
      check_eq("ramp_lut127", lut_mem[127], 127);
      check_eq("ramp_lut255", lut_mem[255], 255);
    end
    if (kind == 1) begin
      check_eq("const_lut127", lut_mem[127], 0);
      check_eq("const_lut128", lut_mem[128], 255);
      check_eq("const_bin128", hist_mem[128], NPIX);
    end
    if (kind == 2) begin
      check_eq("alt_bin_a", hist_mem[a], (NPIX / 4) * 3);
      check_eq("alt_bin_b", hist_mem[b], NPIX / 4);
    end
  endtask

  task automatic reset_mid_accum();
    int guard;
    acc_cnt = 0;
    exp_q.delete();
    @(posedge clk); #1;
    start = 1;
    bus.pix_valid = 1;
    bus.pix_in = 8'($urandom_range(0, 255));
    @(posedge clk); #1 start = 0;
    guard = 0;
    while (acc_cnt < 60 && guard < 1000) begin
      @(posedge clk); #1 bus.pix_in = 8'($urandom_range(0, 255));
      guard++;
    end
    check_eq("rst_pre_accepts", acc_cnt >= 60, 1);
    #2 rstn = 0;
    #1 check_outputs_zero("async_rst");
    exp_lv = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    repeat (10) @(negedge clk);
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_ready", bus.pix_ready, 0);
    check_eq("post_rst_lut_valid", lut_valid, 0);
    @(posedge clk); #1 bus.pix_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rstn = 0;
    start = 0;
    bus.pix_valid = 0;
    bus.pix_in = 0;
    exp_lv = 0;
    #1 check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    repeat (3) @(negedge clk);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_ready", bus.pix_ready, 0);

    run_frame(0, 0, 0, 0);
    run_frame(1, 0, 1, 0);
    run_frame(2, 30, 0, 1);
    run_frame(3, 25, 1, 0);
    reset_mid_accum();
    run_frame(4, 10, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
